// File: rtl/gray_pkg.sv
// Shared definitions for gray-code consumers.
//   state_t   : decoder tracking states (S_INIT, S_TRACK, S_FAULT)
//   gray2bin  : gray-to-binary conversion for any width up to GRAY_MAX_W.
//               Callers zero-extend the gray word to GRAY_MAX_W and take the
//               low WIDTH bits of the result. The prefix XOR is unaffected by
//               the zero padding, so one function serves every WIDTH.
package gray_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_position_decoder_if.sv
// Bus bundle between a gray-coded position source/consumer and the decoder.
//   master : drives gray_in, cnt_clr, err_clr; observes decoded results
//   slave  : the decoder itself
// Signals: gray_in, cnt_clr, err_clr, bin_out, bin_valid, step_pulse,
//          dir_up, pos_count (signed), err_pulse, err_sticky.
interface gray_position_decoder_if #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 16
);
  logic        [WIDTH-1:0]   gray_in;
  logic                      cnt_clr;
  logic                      err_clr;
  logic        [WIDTH-1:0]   bin_out;
  logic                      bin_valid;
  logic                      step_pulse;
  logic                      dir_up;
  logic signed [COUNT_W-1:0] pos_count;
  logic                      err_pulse;
  logic                      err_sticky;

  modport master (
    output gray_in, cnt_clr, err_clr,
    input  bin_out, bin_valid, step_pulse, dir_up, pos_count, err_pulse, err_sticky
  );

  modport slave (
    input  gray_in, cnt_clr, err_clr,
    output bin_out, bin_valid, step_pulse, dir_up, pos_count, err_pulse, err_sticky
  );
endinterface

// File: rtl/gray_sync.sv
// N-stage multi-bit synchroniser chain, all flops reset to 0.
// Ports: clk, rst_n (async active-low), d (asynchronous input word),
//        q (output of the last stage).
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_position_decoder.sv
// Gray-coded position decoder: synchronises gray_in, decodes it to binary,
// classifies each change as up step, down step or illegal jump, and keeps a
// signed wrapping step counter.
// Ports: clk, rst_n (async active-low), bus (gray_position_decoder_if.slave:
//        gray_in, cnt_clr, err_clr in; bin_out, bin_valid, step_pulse,
//        dir_up, pos_count, err_pulse, err_sticky out).
// Optional build macro GRAY_DEC_GLITCH_FILTER_EN: a synchronised sample is
// only used once it has been identical on two consecutive cycles.
module gray_position_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gray_position_decoder_if.slave bus
);

`ifdef GRAY_DEC_GLITCH_FILTER_EN
  localparam int FILL = SYNC_STAGES + 1;
`else
  localparam int FILL = SYNC_STAGES;
`endif
  localparam int FILL_W = $clog2(FILL + 1);

  logic        [WIDTH-1:0]   gray_p0;
  logic                      sample_ok;
  logic        [FILL_W-1:0]  fill_cnt;
  logic                      fill_done;
  logic                      accept;
  logic        [WIDTH-1:0]   bin_new;
  state_t                    state_q, state_d;
  logic                      step_up, step_dn, jump;
  logic        [WIDTH-1:0]   bin_p2;
  logic                      vld_p2, step_p2, dir_p2, err_p2, sticky_p2;
  logic signed [COUNT_W-1:0] pos_p2;

  // Stage p0: synchroniser
  gray_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.gray_in),
    .q     (gray_p0)
  );

  // Stage p1: optional stability filter
`ifdef GRAY_DEC_GLITCH_FILTER_EN
  logic [WIDTH-1:0] hold_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_p1 <= '0;
    else        hold_p1 <= gray_p0;
  end

  assign sample_ok = (gray_p0 == hold_p1);
`else
  assign sample_ok = 1'b1;
`endif

  // The chain holds reset zeros until it has been refilled from gray_in;
  // decoding those would fake a jump from 0 to the real position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          fill_cnt <= '0;
    else if (!fill_done) fill_cnt <= fill_cnt + FILL_W'(1);
  end

  assign fill_done = (fill_cnt == FILL_W'(FILL));
  assign accept    = fill_done && sample_ok;
  assign bin_new   = WIDTH'(gray2bin(GRAY_MAX_W'(gray_p0)));

  // Stage p2: classification and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    jump    = 1'b0;
    case (state_q)
      S_INIT: begin
        if (accept) state_d = S_TRACK;
      end
      S_TRACK: begin
        if (accept) begin
          if (bin_new == bin_p2 + WIDTH'(1)) begin
            step_up = 1'b1;
          end else if (bin_new == bin_p2 - WIDTH'(1)) begin
            step_dn = 1'b1;
          end else if (bin_new != bin_p2) begin
            jump    = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        if (bus.err_clr) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_p2    <= '0;
      vld_p2    <= 1'b0;
      step_p2   <= 1'b0;
      dir_p2    <= 1'b1;
      err_p2    <= 1'b0;
      sticky_p2 <= 1'b0;
      pos_p2    <= '0;
    end else begin
      // bin_p2 doubles as the previous sample; it follows the input in every
      // state once the synchroniser is filled.
      if (accept) bin_p2 <= bin_new;
      vld_p2  <= (state_d != S_INIT);
      step_p2 <= step_up | step_dn;
      if (step_up)      dir_p2 <= 1'b1;
      else if (step_dn) dir_p2 <= 1'b0;
      err_p2 <= jump;
      if (jump)             sticky_p2 <= 1'b1;
      else if (bus.err_clr) sticky_p2 <= 1'b0;
      if (bus.cnt_clr)  pos_p2 <= '0;
      else if (step_up) pos_p2 <= pos_p2 + COUNT_W'(1);
      else if (step_dn) pos_p2 <= pos_p2 - COUNT_W'(1);
    end
  end

  assign bus.bin_out    = bin_p2;
  assign bus.bin_valid  = vld_p2;
  assign bus.step_pulse = step_p2;
  assign bus.dir_up     = dir_p2;
  assign bus.pos_count  = pos_p2;
  assign bus.err_pulse  = err_p2;
  assign bus.err_sticky = sticky_p2;

endmodule

// File: tb/tb_gray_position_decoder.sv
// Testbench for gray_position_decoder: directed scenarios with literal
// expectations plus a randomized walk, all outputs compared every cycle
// against a behavioural model. Honours GRAY_DEC_GLITCH_FILTER_EN.
module tb_gray_position_decoder;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int CW = 16;
`ifdef GRAY_DEC_GLITCH_FILTER_EN
  localparam int LAT  = SS + 2;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = SS + 1;
  localparam bit FILT = 1'b0;
`endif
  localparam int N = 1 << W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_position_decoder_if #(.WIDTH(W), .COUNT_W(CW)) bus ();

  gray_position_decoder #(.WIDTH(W), .SYNC_STAGES(SS), .COUNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests    = 0;
  int fails    = 0;
  int step_cnt = 0;
  int sbin     = 0;
  int r;

  // Behavioural model state
  int          m_edges;
  int          m_hist[$];
  int          m_mode;   // 0 waiting for first sample, 1 tracking, 2 faulted
  int          m_bin;
  bit          m_step, m_dir, m_err, m_sticky;
  logic [CW-1:0] m_pos;

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int g2b(input int g);
    for (int b = 0; b < N; b++) if (b2g(b) == g) return b;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_hist.delete();
    m_mode   = 0;
    m_bin    = 0;
    m_step   = 1'b0;
    m_dir    = 1'b1;
    m_err    = 1'b0;
    m_sticky = 1'b0;
    m_pos    = '0;
  endtask

  // One rising edge: the value used is the one gray_in had SS edges earlier.
  task automatic model_edge(input int g, input bit cc, input bit ec);
    int  n, s, nb, d, pm;
    bit  ready, ok;
    m_edges++;
    m_hist.push_back(g);
    n     = m_edges;
    ready = (n >= LAT);
    ok    = 1'b1;
    if (FILT && ready) ok = (m_hist[n-1-SS] == m_hist[n-2-SS]);
    s      = 0;
    m_err  = 1'b0;
    pm     = m_mode;
    if (ready && ok) begin
      nb = g2b(m_hist[n-1-SS]);
      if (pm == 0) m_mode = 1;
      else if (pm == 1) begin
        d = (nb - m_bin + N) % N;
        if (d == 1) s = 1;
        else if (d == N - 1) s = -1;
        else if (d != 0) begin
          m_err  = 1'b1;
          m_mode = 2;
        end
      end
      m_bin = nb;
    end
    if (pm == 2 && ec) m_mode = 0;
    m_step = (s != 0);
    if (s != 0) m_dir = (s > 0);
    if (m_err)   m_sticky = 1'b1;
    else if (ec) m_sticky = 1'b0;
    m_pos = cc ? '0 : m_pos + CW'(s);
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else        model_edge(int'(bus.gray_in), bus.cnt_clr, bus.err_clr);
    check("m_bin_out",    bus.bin_out,              m_bin);
    check("m_bin_valid",  bus.bin_valid,            m_mode != 0);
    check("m_step_pulse", bus.step_pulse,           m_step);
    check("m_dir_up",     bus.dir_up,               m_dir);
    check("m_pos_count",  $unsigned(bus.pos_count), m_pos);
    check("m_err_pulse",  bus.err_pulse,            m_err);
    check("m_err_sticky", bus.err_sticky,           m_sticky);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      tick();
      if (bus.step_pulse) step_cnt++;
    end
  endtask

  task automatic set_bin(input int b);
    bus.gray_in = W'(b2g(b));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    bus.gray_in = '0;
    bus.cnt_clr = 1'b0;
    bus.err_clr = 1'b0;
    rst_n       = 1'b0;
    tick();
    tick();
    check("rst_valid", bus.bin_valid, 0);
    check("rst_dir",   bus.dir_up, 1);
    check("rst_pos",   $unsigned(bus.pos_count), 0);
    rst_n = 1'b1;

    // First sample after reset
    repeat (LAT - 1) tick();
    check("init_valid_early", bus.bin_valid, 0);
    tick();
    check("init_valid", bus.bin_valid, 1);
    check("init_bin",   bus.bin_out, 0);
    check("init_step",  bus.step_pulse, 0);
    check("init_err",   bus.err_pulse, 0);

    // Up sweep through all codes and wrap to 0
    step_cnt = 0;
    for (int k = 1; k <= N; k++) begin
      set_bin(k % N);
      hold(10);
      check("sweep_bin", bus.bin_out, k % N);
    end
    check("sweep_steps", step_cnt, 16);
    check("sweep_pos",   $unsigned(bus.pos_count), 16);
    check("sweep_dir",   bus.dir_up, 1);

    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    check("clr_pos", $unsigned(bus.pos_count), 0);

    // Down step 0 -> 15
    bus.gray_in = 4'b1000;
    hold(10);
    check("down_bin", bus.bin_out, 15);
    check("down_dir", bus.dir_up, 0);
    check("down_pos", $unsigned(bus.pos_count), 16'hFFFF);
    bus.gray_in = 4'b0000;
    hold(10);
    check("back_pos", $unsigned(bus.pos_count), 0);

    // Illegal jump 0 -> 2
    bus.gray_in = 4'b0011;
    repeat (LAT - 1) tick();
    check("jump_err_early", bus.err_pulse, 0);
    tick();
    check("jump_err",    bus.err_pulse, 1);
    check("jump_sticky", bus.err_sticky, 1);
    check("jump_bin",    bus.bin_out, 2);
    check("jump_pos",    $unsigned(bus.pos_count), 0);
    tick();
    check("jump_err_once", bus.err_pulse, 0);
    check("jump_sticky2",  bus.err_sticky, 1);
    hold(8);
    step_cnt = 0;
    bus.gray_in = 4'b0010;
    hold(10);
    check("fault_steps", step_cnt, 0);
    check("fault_bin",   bus.bin_out, 3);
    check("fault_pos",   $unsigned(bus.pos_count), 0);

    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("errclr_valid",  bus.bin_valid, 0);
    check("errclr_sticky", bus.err_sticky, 0);
    tick();
    check("errclr_valid2", bus.bin_valid, 1);

    step_cnt = 0;
    bus.gray_in = 4'b0110;
    hold(10);
    check("resume_steps", step_cnt, 1);
    check("resume_pos",   $unsigned(bus.pos_count), 1);

    // cnt_clr on the same edge that accepts a step
    set_bin(5);
    repeat (LAT - 1) tick();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    check("clrstep_step", bus.step_pulse, 1);
    check("clrstep_pos",  $unsigned(bus.pos_count), 0);
    check("clrstep_dir",  bus.dir_up, 1);

    for (int k = 6; k <= 10; k++) begin
      set_bin(k);
      hold(6);
    end
    check("pre_rst_pos", $unsigned(bus.pos_count), 5);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #3;
    bus.gray_in = 4'b0110;
    rst_n = 1'b0;
    #1;
    check("arst_pos",    $unsigned(bus.pos_count), 0);
    check("arst_bin",    bus.bin_out, 0);
    check("arst_valid",  bus.bin_valid, 0);
    check("arst_dir",    bus.dir_up, 1);
    check("arst_sticky", bus.err_sticky, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (LAT - 1) tick();
    check("post_rst_valid_early", bus.bin_valid, 0);
    tick();
    check("post_rst_bin",   bus.bin_out, 4'b0100);
    check("post_rst_valid", bus.bin_valid, 1);
    check("post_rst_step",  bus.step_pulse, 0);
    check("post_rst_err",   bus.err_pulse, 0);
    hold(4);

    // Latency of a single step
    set_bin(5);
    repeat (LAT - 1) tick();
    check("lat_early", bus.bin_out, 4);
    tick();
    check("lat_bin",  bus.bin_out, 5);
    check("lat_step", bus.step_pulse, 1);
    hold(4);

`ifdef GRAY_DEC_GLITCH_FILTER_EN
    step_cnt = 0;
    set_bin(6);
    tick();
    set_bin(5);
    hold(10);
    check("glitch_steps", step_cnt, 0);
    check("glitch_bin",   bus.bin_out, 5);
`endif

    // Randomized walk
    sbin = 5;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 70) sbin = (sbin + ($urandom_range(0, 1) != 0 ? 1 : N - 1)) % N;
      else if (r < 80) sbin = (sbin + $urandom_range(2, N - 2)) % N;
      else if (r < 88) begin
        set_bin((sbin + 1) % N);
        tick();
      end
      set_bin(sbin);
      bus.cnt_clr = ($urandom_range(0, 9) == 0);
      bus.err_clr = ($urandom_range(0, 5) == 0);
      tick();
      bus.cnt_clr = 1'b0;
      bus.err_clr = 1'b0;
      hold($urandom_range(0, 6));
    end
    hold(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
